sb_path_sequencer: RTL

Route executor for the bot's node graph. A planned path is loaded as an ordered node list. Once started, the block steps through that list one node at a time. At each step it presents (previous, current, next) node triples to the external map-direction lookup and issues the resulting turn command to the motion controller. It sits between the path planner (writer) and the motor/line-follow FSM (consumer of `dir_cmd`, producer of `node_reached`).

---
 rtl/sb_pkg.sv | 27 ++
 rtl/sb_path_buffer.sv | 54 +++++
 rtl/sb_path_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/sb_pkg.sv
// Shared definitions for the path sequencer: direction codes, node constants and FSM states.
package sb_pkg;

  localparam int NODE_W    = 5;
  localparam int VIRT_NODE = 27;

  localparam logic [2:0] DIR_STOP    = 3'd0;
  localparam logic [2:0] DIR_FORWARD = 3'd1;
  localparam logic [2:0] DIR_LEFT    = 3'd2;
  localparam logic [2:0] DIR_RIGHT   = 3'd3;
  localparam logic [2:0] DIR_EXTREME = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_ISSUE,
    S_WAIT_NODE,
    S_DONE,
    S_FAULT
  } sb_state_e;

  // Only forward/left/right/U-turn are legal moves; stop and 5..7 mean the map has no edge.
  function automatic logic is_move_dir(input logic [2:0] dir);
    return (dir >= DIR_FORWARD) && (dir <= DIR_EXTREME);
  endfunction

endpackage

// File: rtl/sb_path_buffer.sv
// Append-only node list with length tracking and two combinational read ports (idx, idx+1).
module sb_path_buffer #(
  parameter  int MAX_LEN = 32,
  parameter  int NODE_W  = 5,
  localparam int LEN_W   = $clog2(MAX_LEN + 1),
  localparam int IDX_W   = $clog2(MAX_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [NODE_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [NODE_W-1:0] rd_curr,
  output logic [NODE_W-1:0] rd_next,
  output logic [LEN_W-1:0]  len,
  output logic              full
);

  logic [NODE_W-1:0] mem_q [MAX_LEN];
  logic [NODE_W-1:0] mem_d [MAX_LEN];
  logic [LEN_W-1:0]  len_q, len_d;
  logic [IDX_W-1:0]  nxt_idx;
  logic              wr_ok;

  assign full    = (len_q == LEN_W'(MAX_LEN));
  assign wr_ok   = wr_en && !full;
  assign len     = len_q;
  assign nxt_idx = rd_idx + IDX_W'(1);
  assign rd_curr = mem_q[rd_idx];
  assign rd_next = mem_q[nxt_idx];

  always_comb begin
    len_d = len_q;
    mem_d = mem_q;
    if (wr_ok) begin
      len_d                   = len_q + LEN_W'(1);
      mem_d[len_q[IDX_W-1:0]] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q <= '0;
    end else begin
      len_q <= len_d;
    end
  end

  // Node storage is never cleared; len_q alone defines which entries are meaningful.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/sb_path_sequencer.sv
// Walks a loaded node path, querying the external map lookup per hop and issuing turn commands.
module sb_path_sequencer #(
  parameter int MAX_LEN    = 32,
  parameter int NODE_W     = sb_pkg::NODE_W,
  parameter int LOOKUP_LAT = 1,
  parameter int VIRT_NODE  = sb_pkg::VIRT_NODE
) (
  input  logic                         clk_50,
  input  logic                         reset,
  input  logic                         path_wr_en,
  input  logic [NODE_W-1:0]            path_wr_data,
  output logic [$clog2(MAX_LEN+1)-1:0] path_len,
  output logic                         path_full,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         node_reached,
  output logic [NODE_W-1:0]            lk_prev,
  output logic [NODE_W-1:0]            lk_curr,
  output logic [NODE_W-1:0]            lk_next,
  input  logic [2:0]                   lk_dir,
  output logic [2:0]                   dir_cmd,
  output logic                         dir_valid,
  output logic [$clog2(MAX_LEN)-1:0]   step_idx,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);
  import sb_pkg::*;

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int CNT_W = $clog2(LOOKUP_LAT + 1);

  sb_state_e         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NODE_W-1:0] prev_q, prev_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [2:0]        dir_cmd_q, dir_cmd_d;
  logic              dir_valid_q, dir_valid_d;
  logic [NODE_W-1:0] lk_prev_q, lk_prev_d;
  logic [NODE_W-1:0] lk_curr_q, lk_curr_d;
  logic [NODE_W-1:0] lk_next_q, lk_next_d;
  logic              load_lk;
  logic              last_hop;
  logic              buf_wr_en;
  logic [NODE_W-1:0] rd_curr, rd_next;

  assign buf_wr_en = path_wr_en && (state_q == S_IDLE);

  // Read ports follow the next index so the triple can be registered on LOOKUP entry.
  sb_path_buffer #(
    .MAX_LEN (MAX_LEN),
    .NODE_W  (NODE_W)
  ) u_path_buffer (
    .clk     (clk_50),
    .reset   (reset),
    .wr_en   (buf_wr_en),
    .wr_data (path_wr_data),
    .rd_idx  (idx_d),
    .rd_curr (rd_curr),
    .rd_next (rd_next),
    .len     (path_len),
    .full    (path_full)
  );

  assign last_hop = (LEN_W'(idx_q) + LEN_W'(1)) == (path_len - LEN_W'(1));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    prev_d      = prev_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    dir_cmd_d   = dir_cmd_q;
    dir_valid_d = 1'b0;
    load_lk     = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      pend_d  = 1'b0;
      if (dir_cmd_q != DIR_STOP) begin
        dir_cmd_d   = DIR_STOP;
        dir_valid_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start && (path_len >= LEN_W'(2))) begin
            state_d = S_LOOKUP;
            idx_d   = '0;
            prev_d  = NODE_W'(VIRT_NODE);
            cnt_d   = '0;
            pend_d  = 1'b0;
            load_lk = 1'b1;
          end else if (start && (path_len == LEN_W'(1))) begin
            state_d = S_DONE;
            idx_d   = '0;
            if (dir_cmd_q != DIR_STOP) begin
              dir_cmd_d   = DIR_STOP;
              dir_valid_d = 1'b1;
            end
          end
        end
        S_LOOKUP: begin
          if (node_reached) pend_d = 1'b1;
          if (cnt_q == CNT_W'(LOOKUP_LAT)) begin
            dir_valid_d = 1'b1;
            if (is_move_dir(lk_dir)) begin
              state_d   = S_ISSUE;
              dir_cmd_d = lk_dir;
            end else begin
              state_d   = S_FAULT;
              dir_cmd_d = DIR_STOP;
              pend_d    = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        // An arrival seen during LOOKUP/ISSUE is acted on at the ISSUE->WAIT_NODE boundary.
        S_ISSUE, S_WAIT_NODE: begin
          if (state_q == S_ISSUE) state_d = S_WAIT_NODE;
          if (node_reached || pend_q) begin
            pend_d = 1'b0;
            prev_d = lk_curr_q;
            idx_d  = idx_q + IDX_W'(1);
            if (last_hop) begin
              state_d     = S_DONE;
              dir_cmd_d   = DIR_STOP;
              dir_valid_d = 1'b1;
            end else begin
              state_d = S_LOOKUP;
              cnt_d   = '0;
              load_lk = 1'b1;
            end
          end
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    lk_prev_d = lk_prev_q;
    lk_curr_d = lk_curr_q;
    lk_next_d = lk_next_q;
    if (load_lk) begin
      lk_prev_d = prev_d;
      lk_curr_d = rd_curr;
      lk_next_d = rd_next;
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      dir_cmd_q   <= DIR_STOP;
      dir_valid_q <= 1'b0;
      lk_prev_q   <= NODE_W'(VIRT_NODE);
      lk_curr_q   <= NODE_W'(VIRT_NODE);
      lk_next_q   <= NODE_W'(VIRT_NODE);
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      dir_cmd_q   <= dir_cmd_d;
      dir_valid_q <= dir_valid_d;
      lk_prev_q   <= lk_prev_d;
      lk_curr_q   <= lk_curr_d;
      lk_next_q   <= lk_next_d;
    end
  end

  always_ff @(posedge clk_50) begin
    prev_q <= prev_d;
  end

  assign lk_prev   = lk_prev_q;
  assign lk_curr   = lk_curr_q;
  assign lk_next   = lk_next_q;
  assign dir_cmd   = dir_cmd_q;
  assign dir_valid = dir_valid_q;
  assign step_idx  = idx_q;
  assign busy      = (state_q == S_LOOKUP) || (state_q == S_ISSUE) || (state_q == S_WAIT_NODE);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_FAULT);

endmodule
